// File: rtl/rvfi_consistency_checker.sv
// -----------------------------------------------------------------------------
// rvfi_consistency_checker
//
// Passive consumer of the picorv32 RVFI retirement stream. Every record that
// arrives with rvfi_valid=1 is checked for:
//   ORDER     - rvfi_order is not the expected next index
//   PC        - rvfi_pc_rdata breaks continuity with the previous pc_wdata
//   X0        - x0 written with, or read as, a non-zero value
//   RS1/RS2   - read data disagrees with a shadow copy of the register file
//   POST_HALT - a record retires after the halt record
// The per-record verdict is registered and presented one cycle after the
// record was sampled. A sticky flag and the order of the first failing
// record are held until reset for end-of-test checks.
//
// Parameters:
//   REG_CHECK   - 1 builds the shadow register file and the RS1/RS2 checks,
//                 0 ties RS1/RS2 mask bits to 0
//   ORDER_START - expected rvfi_order of the first record after reset
//
// Ports:
//   clk, resetn            - core clock, asynchronous active-low reset
//   rvfi_*                 - RVFI retirement record (one per valid cycle)
//   chk_valid              - pulse: a record was checked
//   chk_err                - pulse: that record failed at least one check
//   chk_err_code[5:0]      - {POST_HALT, RS2, RS1, X0, PC, ORDER}
//   err_sticky             - set at the first error, held until reset
//   err_first_order[63:0]  - rvfi_order of the first failing record
//   retired_cnt[63:0]      - records checked since reset (wraps)
//   halted                 - a halt record has been retired
// -----------------------------------------------------------------------------
module rvfi_consistency_checker #(
  parameter int          REG_CHECK   = 1,
  parameter logic [63:0] ORDER_START = 64'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic        rvfi_intr,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  output logic        chk_valid,
  output logic        chk_err,
  output logic [5:0]  chk_err_code,
  output logic        err_sticky,
  output logic [63:0] err_first_order,
  output logic [63:0] retired_cnt,
  output logic        halted
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Tracking state
  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [63:0] exp_order_r;
  logic [31:0] pc_exp_r;
  logic        pc_exp_valid_r;

  // Output registers
  logic        chk_valid_r;
  logic        chk_err_r;
  logic [5:0]  chk_err_code_r;
  logic        err_sticky_r;
  logic [63:0] err_first_order_r;
  logic [63:0] retired_cnt_r;
  logic        halted_r;

  // Combinational check results for the record currently on the bus
  logic        order_err_s;
  logic        pc_err_s;
  logic        x0_err_s;
  logic        rs1_err_s;
  logic        rs2_err_s;
  logic        post_halt_err_s;
  logic [5:0]  err_code_s;
  logic        rec_err_s;

  // Order, PC, x0 and post-halt checks on the incoming record
  always_comb begin
    order_err_s     = (rvfi_order != exp_order_r);
    pc_err_s        = pc_exp_valid_r && !rvfi_intr && (rvfi_pc_rdata != pc_exp_r);
    x0_err_s        = ((rvfi_rd_addr  == 5'd0) && (rvfi_rd_wdata  != 32'd0)) ||
                      ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != 32'd0)) ||
                      ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != 32'd0));
    post_halt_err_s = (state_r == ST_HALTED);
    err_code_s      = {post_halt_err_s, rs2_err_s, rs1_err_s, x0_err_s, pc_err_s, order_err_s};
    rec_err_s       = rvfi_valid && (err_code_s != 6'd0);
  end

  generate
    if (REG_CHECK != 0) begin : g_shadow
      logic [31:0] shadow_mem_r [32];
      logic [31:0] shadow_vld_r;
      logic        shadow_we_s;

      // Trapped records never commit their rd write
      assign shadow_we_s = rvfi_valid && !rvfi_trap && (rvfi_rd_addr != 5'd0);

      // Compare against the pre-update shadow so rd==rs sees the old value;
      // entries never written are left unchecked
      assign rs1_err_s = (rvfi_rs1_addr != 5'd0) && shadow_vld_r[rvfi_rs1_addr] &&
                         (rvfi_rs1_rdata != shadow_mem_r[rvfi_rs1_addr]);
      assign rs2_err_s = (rvfi_rs2_addr != 5'd0) && shadow_vld_r[rvfi_rs2_addr] &&
                         (rvfi_rs2_rdata != shadow_mem_r[rvfi_rs2_addr]);

      // Shadow register file update from committed rd writes
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          shadow_vld_r <= 32'd0;
          for (int i = 0; i < 32; i++) begin
            shadow_mem_r[i] <= 32'd0;
          end
        end else if (shadow_we_s) begin
          shadow_mem_r[rvfi_rd_addr] <= rvfi_rd_wdata;
          shadow_vld_r[rvfi_rd_addr] <= 1'b1;
        end
      end
    end else begin : g_no_shadow
      assign rs1_err_s = 1'b0;
      assign rs2_err_s = 1'b0;
    end
  endgenerate

  // Lifecycle FSM: HALTED is only left through reset
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rvfi_valid) begin
          state_nxt_s = rvfi_halt ? ST_HALTED : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rvfi_valid && rvfi_halt) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Expected order/PC tracking; order resyncs after every record so a single
  // skip is reported once, not for every record that follows
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      exp_order_r    <= ORDER_START;
      pc_exp_r       <= 32'd0;
      pc_exp_valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (rvfi_valid) begin
        exp_order_r <= rvfi_order + 64'd1;
        if (rvfi_trap) begin
          pc_exp_valid_r <= 1'b0;
        end else begin
          pc_exp_r       <= rvfi_pc_wdata;
          pc_exp_valid_r <= 1'b1;
        end
      end
    end
  end

  // Registered per-record verdict, counters and first-error capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chk_valid_r       <= 1'b0;
      chk_err_r         <= 1'b0;
      chk_err_code_r    <= 6'd0;
      err_sticky_r      <= 1'b0;
      err_first_order_r <= 64'd0;
      retired_cnt_r     <= 64'd0;
      halted_r          <= 1'b0;
    end else begin
      chk_valid_r    <= rvfi_valid;
      chk_err_r      <= rec_err_s;
      chk_err_code_r <= rvfi_valid ? err_code_s : 6'd0;
      halted_r       <= (state_nxt_s == ST_HALTED);
      if (rvfi_valid) begin
        retired_cnt_r <= retired_cnt_r + 64'd1;
      end
      if (rec_err_s && !err_sticky_r) begin
        err_sticky_r      <= 1'b1;
        err_first_order_r <= rvfi_order;
      end
    end
  end

  assign chk_valid       = chk_valid_r;
  assign chk_err         = chk_err_r;
  assign chk_err_code    = chk_err_code_r;
  assign err_sticky      = err_sticky_r;
  assign err_first_order = err_first_order_r;
  assign retired_cnt     = retired_cnt_r;
  assign halted          = halted_r;

endmodule

// File: doc/rvfi_consistency_checker.md
Name: rvfi_consistency_checker

Overview:
Passive RTL checker on the consumer side of the RVFI retirement stream of the picorv32 core. Tracks each retired instruction and flags protocol and architectural inconsistencies:
- order continuity
- PC continuity
- x0 writes
- register read-data mismatches against a shadow register file
- retirement after halt

Outputs feed the testbench scoreboard and a sticky error flag for formal/sim end-of-test checks.

Parameters:
REG_CHECK, 1, enables the shadow register file and the rs1/rs2 data checks (0: RS1/RS2 bits tie to 0, shadow not built)
ORDER_START, 0, expected rvfi_order of the first retirement after reset

Ports:
clk  input  1  core clock
resetn  input  1  asynchronous active-low reset
rvfi_valid  input  1  retirement strobe, one record per asserted cycle
rvfi_order  input  64  retirement index
rvfi_trap  input  1  record trapped
rvfi_halt  input  1  last record before halt
rvfi_intr  input  1  first instruction of a trap handler
rvfi_rs1_addr  input  5  rs1 index
rvfi_rs2_addr  input  5  rs2 index
rvfi_rs1_rdata  input  32  rs1 value read
rvfi_rs2_rdata  input  32  rs2 value read
rvfi_rd_addr  input  5  rd index (0 = no write)
rvfi_rd_wdata  input  32  rd value written
rvfi_pc_rdata  input  32  PC of the record
rvfi_pc_wdata  input  32  next PC
chk_valid  output  1  pulse: a record was checked (registered)
chk_err  output  1  pulse: the checked record failed at least one check
chk_err_code  output  6  per-record error mask: [0] ORDER, [1] PC, [2] X0, [3] RS1, [4] RS2, [5] POST_HALT
err_sticky  output  1  set on first error, held until reset
err_first_order  output  64  rvfi_order of the first failing record
retired_cnt  output  64  records checked since reset
halted  output  1  a halt record has been retired

Behaviour:
Reset (resetn low, asynchronous):
- All outputs 0.
- FSM goes to IDLE.
- Shadow valid bits cleared.
- exp_order = ORDER_START; pc_exp_valid = 0.

FSM states:
- IDLE: no record yet.
- RUN: at least one record retired.
- HALTED: a halt record has been retired.
- Transitions: IDLE→RUN or IDLE→HALTED on the first rvfi_valid; RUN→HALTED on a valid record with rvfi_halt=1. HALTED exits only on reset.

Latency: a record sampled when rvfi_valid=1 at edge N produces chk_valid, chk_err and chk_err_code at edge N+1, stable for one cycle. retired_cnt increments at the same edge. Back-to-back valid cycles are fully supported with no stall and no backpressure.

Checks (evaluated combinationally on the record, then registered):
- ORDER: rvfi_order != exp_order. exp_order becomes rvfi_order+1 after every record, so one error does not cascade.
- PC: pc_exp_valid && !rvfi_intr && rvfi_pc_rdata != pc_exp. After a non-trap record, pc_exp = rvfi_pc_wdata and pc_exp_valid = 1. After a trap record, pc_exp_valid = 0.
- X0: rd_addr==0 && rd_wdata!=0; also rs1_addr==0 && rs1_rdata!=0; also rs2_addr==0 && rs2_rdata!=0.
- RS1 / RS2: addr!=0, shadow entry valid, and rdata != shadow value. The compare uses the pre-update shadow, so rd==rs in the same record compares against the old value. An invalid entry (never written) is not checked.
- Shadow write: on a valid, non-trap record with rd_addr!=0, write rd_wdata and set the valid bit. Trap records do not write.
- POST_HALT: rvfi_valid while in HALTED. All other checks are still evaluated for that record.

Error capture:
- err_sticky sets at the first chk_err.
- err_first_order captures that record's order and is never overwritten afterwards.

Arithmetic: exp_order and retired_cnt are 64-bit and wrap modulo 2^64. Wrap is not an error.

Reset mid-stream: all state clears. The next record is checked against ORDER_START with PC check disabled.

Test Plan:
- Reset, then 4 records order 0..3, pc 0x0→0x4→0x8→0xC, each pc_wdata=pc_rdata+4 → 4 chk_valid pulses, chk_err never set, retired_cnt=4.
- Record order 0 writes x5=0xDEADBEEF; next record order 1 reads rs1=x5 with rdata 0xDEADBEEE → chk_err_code=6'b001000, err_first_order=1, err_sticky=1.
- Orders 0,1,3,4 → ORDER error only on order 3 (mask 6'b000001); order 4 passes.
- Record at pc 0x100 with trap=1, next record at pc 0x10 with intr=1 → no PC error. Same sequence with intr=0 and the trap record's pc_wdata=0x104 → PC error only if the trap bit is cleared, confirming trap disables the continuity check.
- Record with halt=1, then another valid record → halted=1, second record gives mask bit 5. Assert resetn low mid-stream → all outputs 0 asynchronously, and the next order-0 record passes.
- Record with rd_addr=0 and rd_wdata=0x1 → X0 error, mask 6'b000100; a later read of rs1=x0 returning 0 passes.
